// File: rtl/score_display_multi.sv
// Multi-digit score renderer for the Pong VGA pipeline.
// A sequential double-dabble engine converts the binary score to BCD. The
// (x,y) scan position is then mapped onto an external, shared glyph ROM
// through a three-stage registered pipeline that produces 10-bit R/G/B.
// The digits blink for a number of frames after every score change.
module score_display_multi #(
    parameter int X_POS         = 0,
    parameter int Y_POS         = 0,
    parameter int NUM_DIGITS    = 2,
    parameter int SCORE_W       = 8,
    parameter int DIGIT_W       = 27,
    parameter int DIGIT_H       = 38,
    parameter int BLINK_FRAMES  = 24,
    parameter int BLANK_LEADING = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               frame_tick,
    input  logic [SCORE_W-1:0] score,
    output logic [14:0]        rom_addr,
    input  logic [8:0]         rom_data,
    output logic [9:0]         R_num,
    output logic [9:0]         G_num,
    output logic [9:0]         B_num,
    output logic               busy
);

    // Five BCD digits cover the widest score (14 bits, up to 16383).
    localparam int BCD_N      = 5;
    localparam int BCD_W      = 4 * BCD_N;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int DD_W       = BCD_W + SCORE_W;
    localparam int CNT_W      = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int FIELD_W    = NUM_DIGITS * DIGIT_W;
    localparam int ROW_STRIDE = 10 * DIGIT_W;
    localparam int BLINK_W    = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
    // Largest value the field can show before saturating to all nines.
    localparam int MAX_VAL    = (NUM_DIGITS == 1) ? 9 :
                                (NUM_DIGITS == 2) ? 99 :
                                (NUM_DIGITS == 3) ? 999 : 9999;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [SCORE_W-1:0] r_last_score;
    // {BCD accumulator, binary shift register} as one shift chain.
    logic [DD_W-1:0]    r_dd;
    logic [CNT_W-1:0]   r_cnt;
    logic [DISP_W-1:0]  r_bcd_disp;
    logic [BLINK_W-1:0] r_blink_cnt;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [DISP_W-1:0]  w_nines;
    logic               w_sat;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    // NOTE: every signal driven from always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_bcd_adj = r_dd[DD_W-1:SCORE_W];
        for (int i = 0; i < BCD_N; i++) begin
            if (r_dd[SCORE_W + 4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_dd[SCORE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Saturation pattern and the overflow test on the latched score.
    always_comb begin
        w_nines = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_nines[4*i +: 4] = 4'd9;
        end
        w_sat = (32'(r_last_score) > 32'(MAX_VAL));
    end

    // Converter FSM: detect a score change, shift SCORE_W times, then commit.
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_score <= '0;
            r_dd         <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (score != r_last_score) begin
                        r_last_score <= score;
                        r_dd         <= {{BCD_W{1'b0}}, score};
                        r_cnt        <= CNT_W'(SCORE_W - 1);
                        r_state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_dd <= {w_bcd_adj, r_dd[SCORE_W-1:0]} << 1;
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Commit the digits atomically on DONE; blink counter reloads there and
    // otherwise counts frames down to zero. The reload wins over a tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bcd_disp  <= '0;
            r_blink_cnt <= '0;
        end else if (r_state == S_DONE) begin
            r_bcd_disp  <= w_sat ? w_nines : r_dd[SCORE_W +: DISP_W];
            r_blink_cnt <= BLINK_W'(BLINK_FRAMES);
        end else if (frame_tick && (r_blink_cnt != '0)) begin
            r_blink_cnt <= r_blink_cnt - 1'b1;
        end
    end

    assign busy = (r_state == S_SHIFT);

    // ------------------------------------------------------------------
    // Render pipeline
    // ------------------------------------------------------------------
    int          w_dx;
    int          w_dy;
    logic        w_in_field;
    logic [9:0]  w_col;
    logic [9:0]  w_row;
    logic [3:0]  w_value;
    logic        w_zero_run;
    logic        w_lead_blank;
    logic        w_blink_blank;
    logic        w_blank;
    logic [14:0] w_addr;

    logic        r_blank1;
    logic        r_blank2;
    logic [8:0]  w_pix;

    // Locate the scan position: which digit, which glyph column and row,
    // and whether this pixel is blanked.
    always_comb begin
        w_dx         = int'(x) - X_POS;
        w_dy         = int'(y) - Y_POS;
        w_in_field   = (w_dx >= 0) && (w_dx < FIELD_W) && (w_dy >= 0) && (w_dy < DIGIT_H);
        w_row        = w_in_field ? 10'(w_dy) : 10'd0;
        w_col        = '0;
        w_value      = '0;
        w_zero_run   = 1'b1;
        w_lead_blank = 1'b0;
        // Digit 0 is the most significant, i.e. the top nibble of r_bcd_disp.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_zero_run = w_zero_run & (r_bcd_disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            if ((w_dx >= k * DIGIT_W) && (w_dx < (k + 1) * DIGIT_W)) begin
                w_col   = 10'(w_dx - k * DIGIT_W);
                w_value = r_bcd_disp[4*(NUM_DIGITS-1-k) +: 4];
                // The least significant digit is never blanked.
                if ((BLANK_LEADING != 0) && (k < NUM_DIGITS - 1) && w_zero_run) begin
                    w_lead_blank = 1'b1;
                end
            end
        end
        w_blink_blank = (r_blink_cnt != '0) && r_blink_cnt[2];
        w_blank       = !w_in_field || w_lead_blank || w_blink_blank;
        w_addr        = 15'(int'(w_row) * ROW_STRIDE + int'(w_value) * DIGIT_W + int'(w_col));
    end

    // Stage 1 and 2: address to the ROM, blank flag delayed to meet its data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            r_blank1 <= 1'b0;
            r_blank2 <= 1'b0;
        end else begin
            rom_addr <= w_addr;
            r_blank1 <= w_blank;
            r_blank2 <= r_blank1;
        end
    end

    assign w_pix = r_blank2 ? 9'd0 : rom_data;

    // Stage 3: expand each 3-bit channel to the 10-bit mixer format.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            R_num <= 10'h001;
            G_num <= 10'h001;
            B_num <= 10'h001;
        end else begin
            R_num <= {w_pix[8:6], 7'b0000001};
            G_num <= {w_pix[5:3], 7'b0000001};
            B_num <= {w_pix[2:0], 7'b0000001};
        end
    end

endmodule

// File: tb/tb_score_display_multi.sv
// Self-checking bench for score_display_multi. Two instances share all inputs:
// A (2 digits, leading-zero blanking, blinking) and B (3 digits at an offset,
// no blanking, no blinking). Each has its own registered ROM model. Expected
// addresses and colours are queued when a pixel is driven and compared when
// the pipeline delivers them.
module tb_score_display_multi;

    localparam int DW = 27;
    localparam int DH = 38;
    localparam int SW = 8;
    localparam int A_X = 0,   A_Y = 0,  A_N = 2, A_BL = 1, A_BF = 24;
    localparam int B_X = 100, B_Y = 50, B_N = 3, B_BL = 0, B_BF = 0;

    logic          clock;
    logic          reset_n;
    logic [9:0]    x, y;
    logic          frame_tick;
    logic [SW-1:0] score;
    logic [14:0]   addr_a, addr_b;
    logic [8:0]    rom_a, rom_b;
    logic [9:0]    r_a, g_a, b_a, r_b, g_b, b_b;
    logic          busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rises = 0;
    logic busy_prev = 1'b0;

    // Bench model of what each instance should be showing.
    int disp_a = 0;
    int disp_b = 0;
    int blink_a = 0;

    typedef struct {
        int          due;
        int          inst;
        logic [14:0] addr;
        logic [29:0] rgb;
    } exp_t;
    exp_t q_addr[$];
    exp_t q_rgb[$];

    score_display_multi #(
        .X_POS(A_X), .Y_POS(A_Y), .NUM_DIGITS(A_N), .SCORE_W(SW), .DIGIT_W(DW),
        .DIGIT_H(DH), .BLINK_FRAMES(A_BF), .BLANK_LEADING(A_BL)
    ) u_dut_a (
        .clock(clock), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
        .score(score), .rom_addr(addr_a), .rom_data(rom_a),
        .R_num(r_a), .G_num(g_a), .B_num(b_a), .busy(busy_a)
    );

    score_display_multi #(
        .X_POS(B_X), .Y_POS(B_Y), .NUM_DIGITS(B_N), .SCORE_W(SW), .DIGIT_W(DW),
        .DIGIT_H(DH), .BLINK_FRAMES(B_BF), .BLANK_LEADING(B_BL)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .x(x), .y(y), .frame_tick(frame_tick),
        .score(score), .rom_addr(addr_b), .rom_data(rom_b),
        .R_num(r_b), .G_num(g_b), .B_num(b_b), .busy(busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Glyph ROM contents: never zero, so a blanked pixel is always visible.
    function automatic logic [8:0] rom_fn(input logic [14:0] a);
        return 9'((int'(a) % 511) + 1);
    endfunction

    always @(posedge clock) begin
        rom_a <= rom_fn(addr_a);
        rom_b <= rom_fn(addr_b);
        cyc   <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: field membership, ROM address and blanking for one instance.
    function automatic void expect_px(input int inst, input int px, input int py,
                                      output bit infield, output logic [14:0] addr,
                                      output bit blank);
        int xp, yp, n, bl, bc, disp, k, col, row, pw, digit;
        xp   = inst ? B_X : A_X;
        yp   = inst ? B_Y : A_Y;
        n    = inst ? B_N : A_N;
        bl   = inst ? B_BL : A_BL;
        bc   = inst ? 0 : blink_a;
        disp = inst ? disp_b : disp_a;
        infield = (px >= xp) && (px < xp + n * DW) && (py >= yp) && (py < yp + DH);
        addr  = '0;
        blank = !infield;
        if (infield) begin
            k     = (px - xp) / DW;
            col   = (px - xp) % DW;
            row   = py - yp;
            pw    = 10 ** (n - 1 - k);
            digit = (disp / pw) % 10;
            addr  = 15'(row * 10 * DW + digit * DW + col);
            blank = ((bl != 0) && (k < n - 1) && (disp / pw == 0)) ||
                    ((bc != 0) && ((bc & 4) != 0));
        end
    endfunction

    // Drive one scan position for a cycle and queue both instances' results.
    task automatic drive_px(input int px, input int py);
        exp_t e;
        bit inf, blk;
        logic [14:0] a;
        logic [8:0] p;
        x = 10'(px);
        y = 10'(py);
        for (int inst = 0; inst < 2; inst++) begin
            expect_px(inst, px, py, inf, a, blk);
            p = blk ? 9'd0 : rom_fn(a);
            e.inst = inst;
            e.addr = a;
            e.rgb  = {p[8:6], 7'b0000001, p[5:3], 7'b0000001, p[2:0], 7'b0000001};
            if (inf) begin
                e.due = cyc + 1;
                q_addr.push_back(e);
            end
            e.due = cyc + 3;
            q_rgb.push_back(e);
        end
        @(negedge clock);
    endtask

    task automatic drain();
        x = 10'd1023;
        y = 10'd1023;
        repeat (4) @(negedge clock);
        check("drain", 32'(q_rgb.size() + q_addr.size()), 32'd0);
    endtask

    // Output monitor: compare queued expectations as they come due.
    always @(negedge clock) begin
        exp_t e;
        while (q_addr.size() > 0 && q_addr[0].due <= cyc) begin
            e = q_addr.pop_front();
            check($sformatf("addr%0d@%0d", e.inst, e.due),
                  32'(e.inst ? addr_b : addr_a), 32'(e.addr));
        end
        while (q_rgb.size() > 0 && q_rgb[0].due <= cyc) begin
            e = q_rgb.pop_front();
            check($sformatf("rgb%0d@%0d", e.inst, e.due),
                  32'(e.inst ? {r_b, g_b, b_b} : {r_a, g_a, b_a}), 32'(e.rgb));
        end
        if (busy_a && !busy_prev) rises++;
        busy_prev = busy_a;
    end

    task automatic scan_field();
        for (int k = 0; k < A_N; k++) begin
            drive_px(A_X + k * DW, A_Y);
            drive_px(A_X + k * DW, A_Y + 1);
            drive_px(A_X + k * DW + DW - 1, A_Y + DH - 1);
            drive_px(A_X + k * DW + 13, A_Y + 20);
        end
        drive_px(A_X + A_N * DW, A_Y);
        drive_px(A_X, A_Y + DH);
        for (int k = 0; k < B_N; k++) begin
            drive_px(B_X + k * DW, B_Y);
            drive_px(B_X + k * DW + DW - 1, B_Y + DH - 1);
        end
        drive_px(B_X - 1, B_Y);
        drive_px(B_X + B_N * DW, B_Y + 5);
        drain();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_a && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(busy_a), 32'd0);
    endtask

    // Change the score while idle and follow the conversion cycle by cycle.
    task automatic convert(input int v, input bit tick_on_done);
        check($sformatf("busy_pre_%0d", v), 32'(busy_a), 32'd0);
        score = SW'(v);
        for (int i = 1; i <= SW; i++) begin
            @(negedge clock);
            check($sformatf("busy_%0d_c%0d", v, i), 32'(busy_a), 32'd1);
        end
        check($sformatf("busy_b_%0d", v), 32'(busy_b), 32'd1);
        @(negedge clock);
        check($sformatf("busy_done_%0d", v), 32'(busy_a), 32'd0);
        if (tick_on_done) frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        disp_a  = (v > 99) ? 99 : v;
        disp_b  = (v > 999) ? 999 : v;
        blink_a = A_BF;
    endtask

    task automatic tick_and_probe();
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        if (blink_a > 0) blink_a--;
        @(negedge clock);
        drive_px(A_X + DW + 5, A_Y + 3);
        drive_px(A_X + 4, A_Y + 30);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int rise0;
        reset_n    = 1'b0;
        x          = 10'd1023;
        y          = 10'd1023;
        frame_tick = 1'b0;
        score      = '0;
        @(negedge clock);
        check("rst_addr", 32'(addr_a), 32'd0);
        check("rst_rgb", 32'({r_a, g_a, b_a}), 32'({10'h001, 10'h001, 10'h001}));
        check("rst_busy", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("busy_idle_zero", 32'(busy_a), 32'd0);

        // Score 0: A shows blank + "0", B shows "000".
        scan_field();

        // Ordinary conversions, saturation and leading-zero cases.
        convert(42, 1'b0);
        scan_field();
        convert(255, 1'b0);
        scan_field();
        convert(7, 1'b0);
        scan_field();

        // 10, then 11 and 12 on consecutive cycles: exactly two conversions.
        convert(10, 1'b0);
        rise0 = rises;
        score = SW'(11);
        @(negedge clock);
        score = SW'(12);
        wait_idle("idle_11");
        @(negedge clock);
        @(negedge clock);
        check("restart_12", 32'(busy_a), 32'd1);
        wait_idle("idle_12");
        @(negedge clock);
        repeat (3) @(negedge clock);
        check("conv_count", 32'(rises - rise0), 32'd2);
        disp_a  = 12;
        disp_b  = 12;
        blink_a = A_BF;
        scan_field();

        // Blink sequence through and past BLINK_FRAMES ticks.
        convert(21, 1'b0);
        for (int i = 0; i < A_BF + 2; i++) tick_and_probe();
        scan_field();

        // Tick coinciding with DONE: load wins, so 4 ticks later count is 20.
        convert(22, 1'b1);
        for (int i = 0; i < 5; i++) tick_and_probe();

        // Reset in the 4th SHIFT cycle, then the held score converts again.
        x = 10'(A_X + DW + 5);
        y = 10'(A_Y + 3);
        repeat (4) @(negedge clock);
        score = SW'(37);
        repeat (4) @(negedge clock);
        check("busy_before_rst", 32'(busy_a), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_addr", 32'(addr_a), 32'd0);
        check("arst_rgb", 32'({r_a, g_a, b_a}), 32'({10'h001, 10'h001, 10'h001}));
        check("arst_busy", 32'(busy_a), 32'd0);
        disp_a  = 0;
        disp_b  = 0;
        blink_a = 0;
        @(negedge clock);
        x = 10'd1023;
        y = 10'd1023;
        @(negedge clock);
        check("busy_in_rst", 32'(busy_a), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("busy_after_rst", 32'(busy_a), 32'd1);
        wait_idle("idle_37");
        @(negedge clock);
        disp_a  = 37;
        disp_b  = 37;
        blink_a = A_BF;
        scan_field();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
